// File: rtl/fx3_thread_sequencer_if.sv
// Stream/DMA handshake bundle between the word source and the thread sequencer.
// Latency: none; pure signal grouping.
// Backpressure: read_ready/data_available pair; dma_rdy and enable gate burst start only.
interface fx3_thread_sequencer_if #(
   parameter int DATA_W      = 32,
   parameter int NUM_THREADS = 2
);
   logic                   enable;
   logic [DATA_W-1:0]      data_in;
   logic                   data_available;
   logic [NUM_THREADS-1:0] dma_rdy;
   logic                   read_ready;
   logic [1:0]             thread_id;
   logic [DATA_W-1:0]      data_out;
   logic                   data_valid;
   logic                   data_last;
   logic [15:0]            word_count;
   logic [31:0]            burst_count;

   // Source / DMA side: drives the request inputs, observes the sequencer.
   modport master (
      output enable, data_in, data_available, dma_rdy,
      input  read_ready, thread_id, data_out, data_valid, data_last, word_count, burst_count
   );

   // Sequencer side.
   modport slave (
      input  enable, data_in, data_available, dma_rdy,
      output read_ready, thread_id, data_out, data_valid, data_last, word_count, burst_count
   );
endinterface

// File: rtl/fx3_thread_sequencer.sv
// Round-robin DMA thread sequencer: moves fixed-length bursts from a word stream, one thread at a time.
// Latency: an accepted word appears on data_out with data_valid one cycle after acceptance.
// Backpressure: read_ready only in READ; source stalls via data_available; enable/dma_rdy only gate burst start.
module fx3_thread_sequencer #(
   parameter int DATA_W      = 32,
   parameter int NUM_THREADS = 2,
   parameter int BURST_LEN   = 4092
) (
   input logic                   aclk,
   input logic                   aresetn,
   fx3_thread_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      START   = 2'd0,
      WAIT    = 2'd1,
      REQUEST = 2'd2,
      READ    = 2'd3
   } state_t;

   localparam logic [15:0] LAST_WC     = 16'(BURST_LEN - 1);
   localparam logic [1:0]  LAST_THREAD = 2'(NUM_THREADS - 1);

   state_t            state_q, state_d;
   logic [1:0]        thread_id_q, thread_id_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              data_last_q, data_last_d;
   logic [15:0]       word_count_q, word_count_d;
   logic [31:0]       burst_count_q, burst_count_d;

   logic [3:0]        rdy_pad;
   logic              thread_rdy;
   logic              read_ready;
   logic              accept;
   logic              burst_done;

   // Widen dma_rdy to the full thread_id range so out-of-range threads read as not ready.
   always_comb begin
      rdy_pad                    = '0;
      rdy_pad[NUM_THREADS-1:0]   = bus.dma_rdy;
   end

   assign thread_rdy = rdy_pad[thread_id_q];
   assign read_ready = (state_q == READ);
   assign accept     = read_ready & bus.data_available;
   assign burst_done = accept & (word_count_q == LAST_WC);

   // Next-state: start conditions are looked at only in WAIT, so a burst in flight always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         START:   state_d = WAIT;
         WAIT:    if (bus.enable && thread_rdy && bus.data_available) state_d = REQUEST;
         REQUEST: state_d = READ;
         READ:    if (burst_done) state_d = WAIT;
         default: state_d = START;
      endcase
   end

   // Datapath next-state: capture accepted word, count words, close burst and rotate thread.
   always_comb begin
      thread_id_d   = thread_id_q;
      data_out_d    = data_out_q;
      data_valid_d  = accept;
      data_last_d   = burst_done;
      word_count_d  = word_count_q;
      burst_count_d = burst_count_q;
      if (accept) begin
         data_out_d   = bus.data_in;
         word_count_d = word_count_q + 16'd1;
      end
      if (burst_done) begin
         word_count_d  = '0;
         burst_count_d = burst_count_q + 32'd1;
         thread_id_d   = (thread_id_q == LAST_THREAD) ? 2'd0 : thread_id_q + 2'd1;
      end
   end

   // State and datapath registers; reset discards any partial burst.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= START;
         thread_id_q   <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         data_last_q   <= 1'b0;
         word_count_q  <= '0;
         burst_count_q <= '0;
      end else begin
         state_q       <= state_d;
         thread_id_q   <= thread_id_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         data_last_q   <= data_last_d;
         word_count_q  <= word_count_d;
         burst_count_q <= burst_count_d;
      end
   end

   assign bus.read_ready  = read_ready;
   assign bus.thread_id   = thread_id_q;
   assign bus.data_out    = data_out_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.data_last   = data_last_q;
   assign bus.word_count  = word_count_q;
   assign bus.burst_count = burst_count_q;

endmodule

// File: tb/tb_fx3_thread_sequencer.sv
// Directed bench for fx3_thread_sequencer: two-thread/8-word instance plus single-thread/2-word instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises data_available stalls and enable/dma_rdy gating.
module tb_fx3_thread_sequencer;

   logic aclk = 1'b0;
   logic aresetn;
   int   checks = 0;
   int   errors = 0;

   always #5 aclk = ~aclk;

   fx3_thread_sequencer_if #(.DATA_W(32), .NUM_THREADS(2)) bus0 ();
   fx3_thread_sequencer_if #(.DATA_W(32), .NUM_THREADS(1)) bus1 ();

   fx3_thread_sequencer #(.DATA_W(32), .NUM_THREADS(2), .BURST_LEN(8)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus0)
   );

   fx3_thread_sequencer #(.DATA_W(32), .NUM_THREADS(1), .BURST_LEN(2)) dut1 (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus1)
   );

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      bus0.enable = 1'b0; bus0.data_in = '0; bus0.data_available = 1'b0; bus0.dma_rdy = '0;
      bus1.enable = 1'b0; bus1.data_in = '0; bus1.data_available = 1'b0; bus1.dma_rdy = '0;
      aresetn = 1'b0;
      step();
      step();
      aresetn = 1'b1;
   endtask

   // From reset release: START, WAIT->REQUEST, then READ.
   task automatic enter_read();
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL enter_start_rr: got %0b expected 0", bus0.read_ready); end
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL enter_request_rr: got %0b expected 0", bus0.read_ready); end
      step();
      checks++; if (bus0.read_ready !== 1'b1) begin errors++; $display("FAIL enter_read_rr: got %0b expected 1", bus0.read_ready); end
   endtask

   task automatic accept_word(input logic [31:0] val, input logic exp_last, input logic [15:0] exp_wc);
      bus0.data_in        = val;
      bus0.data_available = 1'b1;
      step();
      checks++; if (bus0.data_valid !== 1'b1) begin errors++; $display("FAIL word_valid %0h: got %0b expected 1", val, bus0.data_valid); end
      checks++; if (bus0.data_out !== val) begin errors++; $display("FAIL word_data: got %0h expected %0h", bus0.data_out, val); end
      checks++; if (bus0.data_last !== exp_last) begin errors++; $display("FAIL word_last %0h: got %0b expected %0b", val, bus0.data_last, exp_last); end
      checks++; if (bus0.word_count !== exp_wc) begin errors++; $display("FAIL word_count %0h: got %0d expected %0d", val, bus0.word_count, exp_wc); end
      checks++; if (bus0.read_ready !== !exp_last) begin errors++; $display("FAIL word_rr %0h: got %0b expected %0b", val, bus0.read_ready, !exp_last); end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      bus0.enable = 1'b1; bus0.dma_rdy = 2'b11; bus0.data_available = 1'b1; bus0.data_in = 32'hFFFF_FFFF;
      step();
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL rst_rr: got %0b expected 0", bus0.read_ready); end
      checks++; if (bus0.thread_id !== 2'd0) begin errors++; $display("FAIL rst_thread: got %0d expected 0", bus0.thread_id); end
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", bus0.data_valid); end
      checks++; if (bus0.data_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %0b expected 0", bus0.data_last); end
      checks++; if (bus0.data_out !== 32'd0) begin errors++; $display("FAIL rst_data: got %0h expected 0", bus0.data_out); end
      checks++; if (bus0.word_count !== 16'd0) begin errors++; $display("FAIL rst_wc: got %0d expected 0", bus0.word_count); end
      checks++; if (bus0.burst_count !== 32'd0) begin errors++; $display("FAIL rst_bc: got %0d expected 0", bus0.burst_count); end
      aresetn = 1'b1;
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL rst_first_edge_rr: got %0b expected 0", bus0.read_ready); end
   endtask

   task automatic test_two_bursts();
      do_reset();
      bus0.enable = 1'b1; bus0.dma_rdy = 2'b11; bus0.data_available = 1'b1;
      enter_read();
      checks++; if (bus0.thread_id !== 2'd0) begin errors++; $display("FAIL tb_thread0: got %0d expected 0", bus0.thread_id); end
      for (int i = 0; i < 8; i++) accept_word(32'h100 + 32'(i), (i == 7), (i == 7) ? 16'd0 : 16'(i + 1));
      checks++; if (bus0.burst_count !== 32'd1) begin errors++; $display("FAIL tb_bc1: got %0d expected 1", bus0.burst_count); end
      checks++; if (bus0.thread_id !== 2'd1) begin errors++; $display("FAIL tb_thread1: got %0d expected 1", bus0.thread_id); end
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL tb_idle2_rr: got %0b expected 0", bus0.read_ready); end
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL tb_idle_valid: got %0b expected 0", bus0.data_valid); end
      step();
      checks++; if (bus0.read_ready !== 1'b1) begin errors++; $display("FAIL tb_read2_rr: got %0b expected 1", bus0.read_ready); end
      for (int i = 0; i < 8; i++) accept_word(32'h108 + 32'(i), (i == 7), (i == 7) ? 16'd0 : 16'(i + 1));
      checks++; if (bus0.burst_count !== 32'd2) begin errors++; $display("FAIL tb_bc2: got %0d expected 2", bus0.burst_count); end
      checks++; if (bus0.thread_id !== 2'd0) begin errors++; $display("FAIL tb_thread_wrap: got %0d expected 0", bus0.thread_id); end
   endtask

   task automatic test_dma_wait();
      do_reset();
      bus0.enable = 1'b1; bus0.dma_rdy = 2'b01; bus0.data_available = 1'b1;
      enter_read();
      for (int i = 0; i < 8; i++) accept_word(32'h200 + 32'(i), (i == 7), (i == 7) ? 16'd0 : 16'(i + 1));
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL dw_wait_rr %0d: got %0b expected 0", k, bus0.read_ready); end
         checks++; if (bus0.thread_id !== 2'd1) begin errors++; $display("FAIL dw_wait_thread %0d: got %0d expected 1", k, bus0.thread_id); end
      end
      bus0.dma_rdy = 2'b11;
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL dw_request_rr: got %0b expected 0", bus0.read_ready); end
      step();
      checks++; if (bus0.read_ready !== 1'b1) begin errors++; $display("FAIL dw_read_rr: got %0b expected 1", bus0.read_ready); end
      checks++; if (bus0.thread_id !== 2'd1) begin errors++; $display("FAIL dw_read_thread: got %0d expected 1", bus0.thread_id); end
   endtask

   task automatic test_stall();
      do_reset();
      bus0.enable = 1'b1; bus0.dma_rdy = 2'b11; bus0.data_available = 1'b1;
      enter_read();
      for (int i = 0; i < 4; i++) accept_word(32'h300 + 32'(i), 1'b0, 16'(i + 1));
      bus0.data_available = 1'b0;
      bus0.data_in        = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus0.read_ready !== 1'b1) begin errors++; $display("FAIL st_rr %0d: got %0b expected 1", k, bus0.read_ready); end
         checks++; if (bus0.word_count !== 16'd4) begin errors++; $display("FAIL st_wc %0d: got %0d expected 4", k, bus0.word_count); end
         checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL st_valid %0d: got %0b expected 0", k, bus0.data_valid); end
      end
      for (int i = 4; i < 8; i++) accept_word(32'h300 + 32'(i), (i == 7), (i == 7) ? 16'd0 : 16'(i + 1));
      checks++; if (bus0.burst_count !== 32'd1) begin errors++; $display("FAIL st_bc: got %0d expected 1", bus0.burst_count); end
   endtask

   task automatic test_drop_ignored();
      do_reset();
      bus0.enable = 1'b1; bus0.dma_rdy = 2'b11; bus0.data_available = 1'b1;
      enter_read();
      for (int i = 0; i < 3; i++) accept_word(32'h400 + 32'(i), 1'b0, 16'(i + 1));
      bus0.enable  = 1'b0;
      bus0.dma_rdy = 2'b00;
      for (int i = 3; i < 8; i++) accept_word(32'h400 + 32'(i), (i == 7), (i == 7) ? 16'd0 : 16'(i + 1));
      checks++; if (bus0.burst_count !== 32'd1) begin errors++; $display("FAIL dr_bc: got %0d expected 1", bus0.burst_count); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL dr_idle_rr %0d: got %0b expected 0", k, bus0.read_ready); end
      end
      bus0.enable = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL dr_en_only_rr %0d: got %0b expected 0", k, bus0.read_ready); end
      end
      bus0.dma_rdy = 2'b11;
      step();
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL dr_request_rr: got %0b expected 0", bus0.read_ready); end
      step();
      checks++; if (bus0.read_ready !== 1'b1) begin errors++; $display("FAIL dr_read_rr: got %0b expected 1", bus0.read_ready); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      bus0.enable = 1'b1; bus0.dma_rdy = 2'b11; bus0.data_available = 1'b1;
      enter_read();
      for (int i = 0; i < 5; i++) accept_word(32'h500 + 32'(i), 1'b0, 16'(i + 1));
      aresetn = 1'b0;
      #2;
      checks++; if (bus0.read_ready !== 1'b0) begin errors++; $display("FAIL rm_rr: got %0b expected 0", bus0.read_ready); end
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %0b expected 0", bus0.data_valid); end
      checks++; if (bus0.data_last !== 1'b0) begin errors++; $display("FAIL rm_last: got %0b expected 0", bus0.data_last); end
      checks++; if (bus0.data_out !== 32'd0) begin errors++; $display("FAIL rm_data: got %0h expected 0", bus0.data_out); end
      checks++; if (bus0.word_count !== 16'd0) begin errors++; $display("FAIL rm_wc: got %0d expected 0", bus0.word_count); end
      checks++; if (bus0.burst_count !== 32'd0) begin errors++; $display("FAIL rm_bc: got %0d expected 0", bus0.burst_count); end
      checks++; if (bus0.thread_id !== 2'd0) begin errors++; $display("FAIL rm_thread: got %0d expected 0", bus0.thread_id); end
      step();
      aresetn = 1'b1;
      enter_read();
      checks++; if (bus0.thread_id !== 2'd0) begin errors++; $display("FAIL rm_restart_thread: got %0d expected 0", bus0.thread_id); end
      checks++; if (bus0.word_count !== 16'd0) begin errors++; $display("FAIL rm_restart_wc: got %0d expected 0", bus0.word_count); end
      accept_word(32'h5FF, 1'b0, 16'd1);
      checks++; if (bus0.burst_count !== 32'd0) begin errors++; $display("FAIL rm_restart_bc: got %0d expected 0", bus0.burst_count); end
   endtask

   task automatic test_single_thread();
      do_reset();
      bus1.enable = 1'b1; bus1.dma_rdy = 1'b1; bus1.data_available = 1'b1;
      step();
      step();
      step();
      checks++; if (bus1.read_ready !== 1'b1) begin errors++; $display("FAIL s1_read_rr: got %0b expected 1", bus1.read_ready); end
      for (int b = 0; b < 3; b++) begin
         bus1.data_in = 32'h600 + 32'(2 * b);
         step();
         checks++; if (bus1.data_out !== 32'h600 + 32'(2 * b)) begin errors++; $display("FAIL s1_data_a %0d: got %0h expected %0h", b, bus1.data_out, 32'h600 + 32'(2 * b)); end
         checks++; if (bus1.data_last !== 1'b0) begin errors++; $display("FAIL s1_last_a %0d: got %0b expected 0", b, bus1.data_last); end
         checks++; if (bus1.word_count !== 16'd1) begin errors++; $display("FAIL s1_wc_a %0d: got %0d expected 1", b, bus1.word_count); end
         bus1.data_in = 32'h601 + 32'(2 * b);
         step();
         checks++; if (bus1.data_valid !== 1'b1) begin errors++; $display("FAIL s1_valid_b %0d: got %0b expected 1", b, bus1.data_valid); end
         checks++; if (bus1.data_last !== 1'b1) begin errors++; $display("FAIL s1_last_b %0d: got %0b expected 1", b, bus1.data_last); end
         checks++; if (bus1.word_count !== 16'd0) begin errors++; $display("FAIL s1_wc_b %0d: got %0d expected 0", b, bus1.word_count); end
         checks++; if (bus1.burst_count !== 32'(b + 1)) begin errors++; $display("FAIL s1_bc %0d: got %0d expected %0d", b, bus1.burst_count, b + 1); end
         checks++; if (bus1.thread_id !== 2'd0) begin errors++; $display("FAIL s1_thread %0d: got %0d expected 0", b, bus1.thread_id); end
         checks++; if (bus1.read_ready !== 1'b0) begin errors++; $display("FAIL s1_wait_rr %0d: got %0b expected 0", b, bus1.read_ready); end
         step();
         step();
         checks++; if (bus1.read_ready !== 1'b1) begin errors++; $display("FAIL s1_reread_rr %0d: got %0b expected 1", b, bus1.read_ready); end
      end
   endtask

   initial begin
      aresetn = 1'b0;
      bus0.enable = 1'b0; bus0.data_in = '0; bus0.data_available = 1'b0; bus0.dma_rdy = '0;
      bus1.enable = 1'b0; bus1.data_in = '0; bus1.data_available = 1'b0; bus1.dma_rdy = '0;
      test_reset();
      test_two_bursts();
      test_dma_wait();
      test_stall();
      test_drop_ignored();
      test_reset_mid_read();
      test_single_thread();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fx3_thread_sequencer.md
FX3_THREAD_SEQUENCER -- requirements
Module: fx3_thread_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits.
REQ-002 SHALL have parameter NUM_THREADS, default 2, number of DMA threads serviced round-robin (legal 1..4).
REQ-003 SHALL have parameter BURST_LEN, default 4092, words per thread burst (legal 2..65535).
REQ-004 SHALL have port aclk  input  1  single clock for all logic.
REQ-005 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  permits starting a new burst.
REQ-007 SHALL have port data_in  input  DATA_W  word from stream source.
REQ-008 SHALL have port data_available  input  1  source holds a valid word this cycle.
REQ-009 SHALL have port dma_rdy  input  NUM_THREADS  per-thread DMA buffer free flag.
REQ-010 SHALL have port read_ready  output  1  sequencer accepts data_in this cycle.
REQ-011 SHALL have port thread_id  output  2  thread currently being serviced.
REQ-012 SHALL have port data_out  output  DATA_W  registered accepted word.
REQ-013 SHALL have port data_valid  output  1  data_out valid pulse.
REQ-014 SHALL have port data_last  output  1  marks final word of a burst, coincident with data_valid.
REQ-015 SHALL have port word_count  output  16  words accepted in current burst.
REQ-016 SHALL have port burst_count  output  32  completed bursts since reset, wraps at 2^32.

Function
REQ-017 SHALL implement states START, WAIT, REQUEST, READ in a registered state machine.
REQ-018 START SHALL move to WAIT on the first clock after reset release, with thread_id=0.
REQ-019 WAIT SHALL move to REQUEST when enable=1, dma_rdy[thread_id]=1 and data_available=1, else remain.
REQ-020 REQUEST SHALL last exactly one cycle, then move to READ; read_ready=0 in REQUEST.
REQ-021 read_ready SHALL be 1 only in READ.
REQ-022 A word SHALL be accepted in a cycle where read_ready=1 and data_available=1; no other cycle accepts.
REQ-023 On acceptance, data_out<=data_in and data_valid=1 on the next cycle (latency 1); data_valid=0 otherwise.
REQ-024 word_count SHALL increment by 1 per accepted word and hold when data_available=0 (stall, read_ready stays 1).
REQ-025 On acceptance with word_count=BURST_LEN-1: data_last=1 with that word, word_count<=0, burst_count+1, thread_id advances (NUM_THREADS-1 wraps to 0), state<=WAIT.
REQ-026 Deassertion of dma_rdy[thread_id] or enable during READ SHALL NOT abort the burst; they are sampled only in WAIT.
REQ-027 With NUM_THREADS=1, thread_id SHALL stay 0 and every burst re-enters WAIT.
REQ-028 A new burst SHALL never begin without passing through WAIT and REQUEST (minimum 2 idle cycles between bursts).
REQ-029 Unused state encodings SHALL recover to START on the next clock.

Reset
REQ-030 aresetn=0 SHALL asynchronously force state=START, thread_id=0, read_ready=0, data_valid=0, data_last=0, data_out=0, word_count=0, burst_count=0.
REQ-031 Reset asserted mid-READ SHALL discard the partial burst; no data_last or burst_count update occurs.
REQ-032 All registers SHALL leave reset synchronously on the first aclk edge after aresetn rises.

Verification (BURST_LEN=8, NUM_THREADS=2 unless noted)
REQ-033 data_available=1, dma_rdy=2'b11, enable=1, counting data_in -> two bursts of 8 words, thread_id 0 then 1 then 0, data_last on words 8 and 16, burst_count=2, 2 idle cycles between bursts.
REQ-034 dma_rdy=2'b01 after first burst -> sequencer waits in WAIT on thread 1 with read_ready=0; raising dma_rdy[1] -> REQUEST next cycle, READ after.
REQ-035 data_available low for 3 cycles after word 4 -> read_ready stays 1, word_count holds at 4, no data_valid pulses, burst completes with exactly 8 words, no duplicates.
REQ-036 dma_rdy and enable dropped to 0 at word 3 -> burst still completes 8 words; no next burst starts until both return.
REQ-037 aresetn pulsed low at word 5 -> all outputs at reset values immediately, burst_count=0, next burst starts on thread 0 at word_count 0.
REQ-038 NUM_THREADS=1, BURST_LEN=2 -> thread_id constant 0, data_last on every second word, burst_count increments per 2 words.
